// File: rtl/pixel_average_downscale_2x_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pixel_average_downscale_2x_pkg
//  Description : Shared definitions for the 2x zoom blocks: FSM state
//                encoding, default frame geometry and an address-width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package pixel_average_downscale_2x_pkg;

    // Coprocessor zoom FSM encoding, shared with the replication block
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } zoom_state_t;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_IMG_W  = 160;
    localparam int DEF_IMG_H  = 120;

    // Index width for a range of n entries, never narrower than one bit
    function automatic int addr_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage : pixel_average_downscale_2x_pkg
`default_nettype wire

// File: rtl/pixel_average_downscale_2x_line_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : downscale_line_buffer
//  Description : Horizontal pair-sum store for one even row. Synchronous
//                write, asynchronous read so the odd-row adder sees the entry
//                in the same cycle as the incoming pixel.
//  Revision    : 1.0 - initial release
// ============================================================================
module downscale_line_buffer
    import pixel_average_downscale_2x_pkg::*;
#(
    parameter int DEPTH = 80,
    parameter int WIDTH = 9,
    parameter int AW    = addr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    // Storage is never reset: every entry read on an odd row was written on
    // the even row just before it.
    logic [WIDTH-1:0] r_mem [DEPTH];

    // Write one pair sum per even-row block
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule : downscale_line_buffer
`default_nettype wire

// File: rtl/pixel_average_downscale_2x.sv
`default_nettype none
// ============================================================================
//  Module      : pixel_average_downscale_2x
//  Description : 2x zoom-out by 2x2 block averaging. Consumes one raster
//                frame of IMG_W x IMG_H pixels and emits one IMG_W/2 x IMG_H/2
//                frame, one rounded average per 2x2 block.
//  Revision    : 1.0 - initial release
// ============================================================================
module pixel_average_downscale_2x
    import pixel_average_downscale_2x_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int IMG_W  = DEF_IMG_W,
    parameter int IMG_H  = DEF_IMG_H
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [DATA_W-1:0] pixel_in,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] pixel_out,
    output logic              out_valid,
    output logic              busy,
    output logic              done
);

    localparam int COL_W    = addr_width(IMG_W);
    localparam int ROW_W    = addr_width(IMG_H);
    localparam int LB_DEPTH = IMG_W / 2;
    localparam int LB_AW    = addr_width(LB_DEPTH);
    localparam int SUM1_W   = DATA_W + 1;
    localparam int SUM2_W   = DATA_W + 2;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

    zoom_state_t        r_state;
    zoom_state_t        w_state_next;

    logic [COL_W-1:0]   r_col;
    logic [ROW_W-1:0]   r_row;
    logic [DATA_W-1:0]  r_pair_sum;
    logic [DATA_W-1:0]  r_pixel_out;
    logic               r_out_valid;

    logic               w_beat;
    logic               w_col_last;
    logic               w_row_last;
    logic               w_frame_last;
    logic               w_odd_col;
    logic               w_odd_row;
    logic               w_lb_we;
    logic               w_out_fire;
    logic [LB_AW-1:0]   w_lb_addr;
    logic [SUM1_W-1:0]  w_lb_wdata;
    logic [SUM1_W-1:0]  w_lb_rdata;
    logic [SUM2_W-1:0]  w_total;
    logic [DATA_W-1:0]  w_avg;

    // ------------------------------------------------------------------
    // Handshake and position decode
    // ------------------------------------------------------------------
    assign in_ready     = (r_state == ST_RUN);
    assign busy         = (r_state != ST_IDLE);
    assign done         = (r_state == ST_DONE);

    assign w_beat       = in_valid & in_ready;
    assign w_col_last   = (r_col == COL_LAST);
    assign w_row_last   = (r_row == ROW_LAST);
    assign w_frame_last = w_beat & w_col_last & w_row_last;
    assign w_odd_col    = r_col[0];
    assign w_odd_row    = r_row[0];

    // ------------------------------------------------------------------
    // Datapath: even rows store horizontal pair sums, odd rows complete
    // the 2x2 block and round half-up. The largest total (4*max + 2)
    // still fits in DATA_W+2 bits, so the shifted average fits DATA_W.
    // ------------------------------------------------------------------
    assign w_lb_addr  = LB_AW'(r_col >> 1);
    assign w_lb_we    = w_beat & ~w_odd_row & w_odd_col;
    assign w_lb_wdata = SUM1_W'(r_pair_sum) + SUM1_W'(pixel_in);
    assign w_total    = SUM2_W'(w_lb_rdata) + SUM2_W'(r_pair_sum) + SUM2_W'(pixel_in);
    assign w_avg      = DATA_W'((w_total + SUM2_W'(2)) >> 2);
    assign w_out_fire = w_beat & w_odd_row & w_odd_col;

    downscale_line_buffer #(
        .DEPTH (LB_DEPTH),
        .WIDTH (SUM1_W),
        .AW    (LB_AW)
    ) u_line_buffer (
        .clk   (clk),
        .we    (w_lb_we),
        .waddr (w_lb_addr),
        .wdata (w_lb_wdata),
        .raddr (w_lb_addr),
        .rdata (w_lb_rdata)
    );

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state: start only counts in IDLE, DONE lasts one cycle
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE: if (start)        w_state_next = ST_RUN;
            ST_RUN:  if (w_frame_last) w_state_next = ST_DONE;
            ST_DONE:                   w_state_next = ST_IDLE;
            default:                   w_state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Raster position counters: cleared on an accepted start, advanced
    // only on beats so input gaps simply stall.
    // ------------------------------------------------------------------

    // Column / row position of the next pixel to be accepted
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_col <= '0;
            r_row <= '0;
        end else if ((r_state == ST_IDLE) && start) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_beat) begin
            if (w_col_last) begin
                r_col <= '0;
                r_row <= w_row_last ? '0 : ROW_W'(r_row + 1'b1);
            end else begin
                r_col <= COL_W'(r_col + 1'b1);
            end
        end
    end

    // Left pixel of the current horizontal pair
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pair_sum <= '0;
        end else if (w_beat && !w_odd_col) begin
            r_pair_sum <= pixel_in;
        end
    end

    // Output register: one-cycle valid pulse, value held between pulses
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pixel_out <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= w_out_fire;
            if (w_out_fire) begin
                r_pixel_out <= w_avg;
            end
        end
    end

    assign pixel_out = r_pixel_out;
    assign out_valid = r_out_valid;

endmodule : pixel_average_downscale_2x
`default_nettype wire

// File: tb/tb_pixel_average_downscale_2x.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pixel_average_downscale_2x
//  Description : Self-checking bench. Instance A is a 4x2 frame for the
//                hand-computed cases, instance B the full 160x120 frame for
//                randomised gaps and mid-frame reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pixel_average_downscale_2x;

    localparam int AW_ = 4, AH_ = 2, BW_ = 160, BH_ = 120;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a_n, start_a, in_valid_a, in_ready_a, out_valid_a, busy_a, done_a;
    logic [7:0] pin_a, pout_a;
    logic       rst_b_n, start_b, in_valid_b, in_ready_b, out_valid_b, busy_b, done_b;
    logic [7:0] pin_b, pout_b;

    pixel_average_downscale_2x #(.DATA_W(8), .IMG_W(AW_), .IMG_H(AH_)) u_dut_a (
        .clk(clk), .reset_n(rst_a_n), .start(start_a), .pixel_in(pin_a),
        .in_valid(in_valid_a), .in_ready(in_ready_a), .pixel_out(pout_a),
        .out_valid(out_valid_a), .busy(busy_a), .done(done_a));

    pixel_average_downscale_2x #(.DATA_W(8), .IMG_W(BW_), .IMG_H(BH_)) u_dut_b (
        .clk(clk), .reset_n(rst_b_n), .start(start_b), .pixel_in(pin_b),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .pixel_out(pout_b),
        .out_valid(out_valid_b), .busy(busy_b), .done(done_b));

    int tests = 0, fails = 0;
    int exp_a[$], exp_b[$], cap_a[$];
    int last_a = 0, last_b = 0, e_a, e_b;
    int done_cnt_a = 0, done_cnt_b = 0, out_cnt_b = 0;
    bit prev_done_a = 0, prev_done_b = 0, chk_en = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s", name);
    endtask

    // Compare process: checks both instances on every falling edge
    always @(negedge clk) begin
        if (chk_en) begin
            if (out_valid_a === 1'b1) begin
                if (exp_a.size() == 0) fail_now("a_unexpected_output");
                else begin
                    e_a = exp_a.pop_front();
                    chk("a_pixel", pout_a, e_a);
                    last_a = e_a;
                    cap_a.push_back(int'(pout_a));
                end
            end else chk("a_hold", pout_a, last_a);
            chk("a_ready_vs_state", in_ready_a, busy_a & ~done_a);
            if (done_a === 1'b1) begin
                chk("a_done_with_last_valid", out_valid_a, 1);
                chk("a_done_outputs_left", exp_a.size(), 0);
                done_cnt_a++;
            end
            if (prev_done_a) chk("a_busy_after_done", busy_a, 0);
            prev_done_a = (done_a === 1'b1);

            if (out_valid_b === 1'b1) begin
                out_cnt_b++;
                if (exp_b.size() == 0) fail_now("b_unexpected_output");
                else begin
                    e_b = exp_b.pop_front();
                    chk("b_pixel", pout_b, e_b);
                    last_b = e_b;
                end
            end else chk("b_hold", pout_b, last_b);
            chk("b_ready_vs_state", in_ready_b, busy_b & ~done_b);
            if (done_b === 1'b1) begin
                chk("b_done_with_last_valid", out_valid_b, 1);
                chk("b_done_outputs_left", exp_b.size(), 0);
                done_cnt_b++;
            end
            if (prev_done_b) chk("b_busy_after_done", busy_b, 0);
            prev_done_b = (done_b === 1'b1);
        end
    end

    task automatic drive(input int inst, input logic v, input logic [7:0] p, input logic s);
        if (inst == 0) begin in_valid_a = v; pin_a = p; start_a = s; end
        else           begin in_valid_b = v; pin_b = p; start_b = s; end
    endtask

    function automatic logic get_ready(input int inst);
        return (inst == 0) ? in_ready_a : in_ready_b;
    endfunction

    function automatic logic get_busy(input int inst);
        return (inst == 0) ? busy_a : busy_b;
    endfunction

    function automatic int exp_left(input int inst);
        return (inst == 0) ? exp_a.size() : exp_b.size();
    endfunction

    // Runs one frame on an instance; abort_at >= 0 resets instance B after
    // that many accepted beats.
    task automatic run_frame(input int inst, input int w, input int h, input int pix[],
                             input int vpct, input int abort_at, input bit start_noise);
        int  n, idx, cyc, s;
        bit  v, beat;
        n = w * h; idx = 0; cyc = 0;
        // Reference: rounded mean of each 2x2 block, in output raster order
        for (int r = 0; r < h; r += 2) begin
            for (int c = 0; c < w; c += 2) begin
                s = pix[r*w+c] + pix[r*w+c+1] + pix[(r+1)*w+c] + pix[(r+1)*w+c+1];
                if (inst == 0) exp_a.push_back((s + 2) / 4);
                else           exp_b.push_back((s + 2) / 4);
            end
        end
        // Junk pixels offered in IDLE must be ignored
        drive(inst, 1'b1, 8'hAB, 1'b0);
        repeat (2) begin @(posedge clk); #1; end
        drive(inst, 1'b0, 8'h00, 1'b1);
        @(posedge clk); #1;
        drive(inst, 1'b0, 8'h00, 1'b0);
        chk("in_ready_after_start", get_ready(inst), 1);
        while (idx < n) begin
            if (abort_at >= 0 && idx == abort_at) begin
                rst_b_n = 1'b0;
                drive(1, 1'b0, 8'h00, 1'b0);
                exp_b.delete();
                last_b = 0;
                #1;
                chk("abort_out_valid", out_valid_b, 0);
                chk("abort_pixel_out", pout_b, 0);
                chk("abort_busy", busy_b, 0);
                chk("abort_in_ready", in_ready_b, 0);
                chk("abort_done", done_b, 0);
                repeat (2) @(posedge clk);
                #1 rst_b_n = 1'b1;
                @(posedge clk); #1;
                return;
            end
            v = ($urandom_range(0, 99) < vpct);
            drive(inst, v, v ? 8'(pix[idx]) : 8'($urandom),
                  start_noise && ($urandom_range(0, 19) == 0));
            beat = v && get_ready(inst);
            @(posedge clk); #1;
            if (beat) idx++;
            cyc++;
            if (cyc > n * 20 + 50) begin
                fail_now("frame_timeout");
                break;
            end
        end
        drive(inst, 1'b0, 8'h00, 1'b0);
        if (idx == n) begin
            // Now in the DONE cycle: a start here must not relaunch
            chk("busy_in_done", get_busy(inst), 1);
            drive(inst, 1'b0, 8'h00, 1'b1);
            @(posedge clk); #1;
            drive(inst, 1'b0, 8'h00, 1'b0);
            chk("start_in_done_ignored", get_ready(inst), 0);
        end
        repeat (2) begin @(posedge clk); #1; end
        chk("frame_outputs_left", exp_left(inst), 0);
    endtask

    task automatic run_small(input int lit[8], input int vpct, input bit noise,
                             input int e0, input int e1, input bit pin_vals);
        int fa[];
        int d0;
        fa = new[8];
        foreach (lit[i]) fa[i] = lit[i];
        cap_a.delete();
        d0 = done_cnt_a;
        run_frame(0, AW_, AH_, fa, vpct, -1, noise);
        chk("a_done_pulses", done_cnt_a - d0, 1);
        chk("a_output_count", cap_a.size(), 2);
        if (pin_vals && cap_a.size() == 2) begin
            chk("a_literal_out0", cap_a[0], e0);
            chk("a_literal_out1", cap_a[1], e1);
        end
    endtask

    initial begin
        int lit[8];
        int fb[];
        int d0, o0;

        rst_a_n = 1'b0; rst_b_n = 1'b0;
        drive(0, 1'b0, 8'h00, 1'b0);
        drive(1, 1'b0, 8'h00, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_a_pixel_out", pout_a, 0);
        chk("rst_a_out_valid", out_valid_a, 0);
        chk("rst_a_busy", busy_a, 0);
        chk("rst_a_done", done_a, 0);
        chk("rst_a_in_ready", in_ready_a, 0);
        chk("rst_b_pixel_out", pout_b, 0);
        chk("rst_b_busy", busy_b, 0);
        rst_a_n = 1'b1; rst_b_n = 1'b1;
        chk_en = 1'b1;
        @(posedge clk); #1;

        // Uniform frame
        lit = '{100, 100, 100, 100, 100, 100, 100, 100};
        run_small(lit, 100, 1'b0, 100, 100, 1'b1);
        // Two distinct blocks: 140 -> 35, 220 -> 55; start noise during RUN
        lit = '{10, 20, 30, 40, 50, 60, 70, 80};
        run_small(lit, 100, 1'b1, 35, 55, 1'b1);
        // Saturating block and a total of 1 rounding down
        lit = '{255, 255, 0, 0, 255, 255, 0, 1};
        run_small(lit, 100, 1'b0, 255, 0, 1'b1);
        // Total 2 rounds up to 1; 7+9+11+13 = 40 -> 10
        lit = '{0, 1, 7, 9, 0, 1, 11, 13};
        run_small(lit, 70, 1'b1, 1, 10, 1'b1);
        // Random small frames with gaps
        for (int k = 0; k < 6; k++) begin
            foreach (lit[i]) lit[i] = $urandom_range(0, 255);
            run_small(lit, 50, 1'b1, 0, 0, 1'b0);
        end

        // Full-size frame aborted in the middle of row 3
        fb = new[BW_ * BH_];
        foreach (fb[i]) fb[i] = $urandom_range(0, 255);
        d0 = done_cnt_b;
        run_frame(1, BW_, BH_, fb, 70, 3 * BW_ + 51, 1'b0);
        chk("b_abort_no_done", done_cnt_b - d0, 0);

        // Fresh full-size frame with ~50% gaps after the abort
        foreach (fb[i]) fb[i] = $urandom_range(0, 255);
        d0 = done_cnt_b;
        o0 = out_cnt_b;
        run_frame(1, BW_, BH_, fb, 50, -1, 1'b1);
        chk("b_done_pulses", done_cnt_b - d0, 1);
        chk("b_output_count", out_cnt_b - o0, (BW_ / 2) * (BH_ / 2));

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_pixel_average_downscale_2x
`default_nettype wire
